// File: rtl/debug_fifo_pkg.sv
// Shared constants and sizing helpers for the debug-module FIFOs.
package debug_fifo_pkg;

   // Default geometry of a generic debug FIFO instance
   localparam int DEF_WIDTH     = 32;
   localparam int DEF_DEPTH     = 4;

   // DMI request carries addr+data+op, response carries data+resp code
   localparam int DMI_REQ_WIDTH = 41;
   localparam int DMI_RSP_WIDTH = 34;
   localparam int DMI_DEPTH     = 2;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Pointer width: index bits plus one wrap bit to tell full from empty
   function automatic int ptr_w(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/debug_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read,
// synchronous clear so a reset FIFO presents zero on its read port.
module debug_fifo_ram
   import debug_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage update: clear on reset, otherwise write the addressed entry
   always_ff @(posedge CLK) begin
      if (RES) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, almost-full,
// flush and sticky overflow/underflow flags for debug status reporting.
module debug_sync_fifo
   import debug_fifo_pkg::*;
#(
   parameter int  WIDTH    = DEF_WIDTH,
   parameter int  DEPTH    = DEF_DEPTH,
   parameter int  AF_LEVEL = DEPTH - 1,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             FLUSH,
   input  logic             WR_PUT,
   output logic             WR_RDY,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             RD_GET,
   output logic             RD_RDY,
   output logic [WIDTH-1:0] RD_DATA,
   output logic [AW:0]      LEVEL,
   output logic             ALMOST_FULL,
   output logic             ERR_OVF,
   output logic             ERR_UDF,
   input  logic             ERR_CLR
);

   localparam int        PW     = ptr_w(DEPTH);
   localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          full, empty;
   logic          we, re;
   logic          ovf_set, udf_set;

   // Status decodes come from registered pointers only
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   assign WR_RDY      = ~full;
   assign RD_RDY      = ~empty;
   assign LEVEL       = wptr_q - rptr_q;
   assign ALMOST_FULL = (LEVEL >= AF_LVL);
   assign ERR_OVF     = ovf_q;
   assign ERR_UDF     = udf_q;

   // A flush swallows same-cycle requests: no transfer, no error
   assign we      = WR_PUT & ~full  & ~FLUSH;
   assign re      = RD_GET & ~empty & ~FLUSH;
   assign ovf_set = WR_PUT &  full  & ~FLUSH;
   assign udf_set = RD_GET &  empty & ~FLUSH;

   // Next-state for pointers and sticky flags; a new error beats a clear
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (FLUSH) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (we) wptr_d = wptr_q + 1'b1;
         if (re) rptr_d = rptr_q + 1'b1;
      end
      if (ERR_CLR) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RES) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   debug_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .CLK     (CLK),
      .RES     (RES),
      .we_i    (we),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (WR_DATA),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (RD_DATA)
   );

endmodule

// File: tb/tb_debug_sync_fifo.sv
// Scoreboard bench for debug_sync_fifo: directed scenarios then random
// traffic, compared against a queue-based model of the FIFO.
module tb_debug_sync_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AF    = DEPTH - 1;
   localparam int AW    = 2;

   logic             CLK, RES, FLUSH, WR_PUT, RD_GET, ERR_CLR;
   logic             WR_RDY, RD_RDY, ALMOST_FULL, ERR_OVF, ERR_UDF;
   logic [WIDTH-1:0] WR_DATA, RD_DATA;
   logic [AW:0]      LEVEL;

   int checks = 0;
   int errors = 0;

   // Model: contents of the FIFO and sticky flags, as of the last edge
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] exp_q[$];
   bit               m_ovf, m_udf;

   debug_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .CLK(CLK), .RES(RES), .FLUSH(FLUSH),
      .WR_PUT(WR_PUT), .WR_RDY(WR_RDY), .WR_DATA(WR_DATA),
      .RD_GET(RD_GET), .RD_RDY(RD_RDY), .RD_DATA(RD_DATA),
      .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL),
      .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF), .ERR_CLR(ERR_CLR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("level",  64'(LEVEL), 64'(mq.size()));
      chk("wr_rdy", 64'(WR_RDY), 64'(mq.size() < DEPTH));
      chk("rd_rdy", 64'(RD_RDY), 64'(mq.size() > 0));
      chk("afull",  64'(ALMOST_FULL), 64'(mq.size() >= AF));
      chk("ovf",    64'(ERR_OVF), 64'(m_ovf));
      chk("udf",    64'(ERR_UDF), 64'(m_udf));
      if (mq.size() > 0) chk("head", 64'(RD_DATA), 64'(mq[0]));
   endtask

   // One clock: drive, advance the model to the post-edge state, then check
   task automatic cyc(input bit put, input logic [WIDTH-1:0] d, input bit get,
                      input bit fl, input bit clr, input bit rs);
      bit full, empty;
      WR_PUT = put; WR_DATA = d; RD_GET = get; FLUSH = fl; ERR_CLR = clr; RES = rs;
      if (rs) begin
         mq.delete(); exp_q.delete(); m_ovf = 0; m_udf = 0;
      end else if (fl) begin
         mq.delete(); exp_q.delete();
         if (clr) begin m_ovf = 0; m_udf = 0; end
      end else begin
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         if (clr) begin m_ovf = 0; m_udf = 0; end
         if (put && full)  m_ovf = 1;
         if (get && empty) m_udf = 1;
         if (get && !empty) void'(mq.pop_front());
         if (put && !full) begin mq.push_back(d); exp_q.push_back(d); end
      end
      @(posedge CLK); #1;
      check_status();
   endtask

   // Monitor: every accepted pop must present the oldest written word
   always @(negedge CLK) begin
      if (!RES && !FLUSH && RD_GET && RD_RDY) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected got=%0h expected=none", RD_DATA);
         end else begin
            chk("pop_data", 64'(RD_DATA), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      RES = 1; FLUSH = 0; WR_PUT = 0; RD_GET = 0; ERR_CLR = 0; WR_DATA = '0;

      // Reset then idle
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst_rd_data", 64'(RD_DATA), 64'h0);
      cyc(0, 0, 0, 0, 0, 0);

      // Fill to full, overflow attempt, drain in order
      cyc(1, 32'h11, 0, 0, 0, 0);
      cyc(1, 32'h22, 0, 0, 0, 0);
      cyc(1, 32'h33, 0, 0, 0, 0);
      cyc(1, 32'h44, 0, 0, 0, 0);
      cyc(1, 32'h99, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // Wrap with occupancy held at two
      cyc(1, 32'hF0, 0, 0, 0, 0);
      cyc(1, 32'hF1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 32'h100 + i, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Empty get, clear, clear colliding with a new empty get
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // Flush with same-cycle put and get, then reuse
      cyc(1, 32'hA1, 0, 0, 0, 0);
      cyc(1, 32'hA2, 0, 0, 0, 0);
      cyc(1, 32'hA3, 0, 0, 0, 0);
      cyc(1, 32'hAA, 1, 1, 0, 0);
      cyc(1, 32'h55, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Full FIFO: get succeeds, put refused and flagged
      for (int i = 0; i < DEPTH; i++) cyc(1, 32'hC0 + i, 0, 0, 0, 0);
      cyc(1, 32'hDD, 1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // Random traffic with alternating fill/drain bias
      for (int i = 0; i < 3000; i++) begin
         bit fill, put, get, fl, clr, rs;
         fill = ((i / 40) % 2) == 0;
         put  = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         get  = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 59) == 0);
         clr  = !fl && ($urandom_range(0, 9) == 0);
         rs   = ($urandom_range(0, 299) == 0);
         cyc(put, $urandom, get, fl, clr, rs);
      end

      // Drain leftovers so every queued word passes the monitor
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
